// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream image loader that holds the core in reset until loaded
// Optional trailing checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module boot_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_resetn,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_cnt
);

  localparam logic [16:0]       MAX_WORDS = 17'(1) << (ADDR_W - 2);
  localparam logic [ADDR_W-2:0] CNT_ONE   = 1;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t FINAL = CSUM;
`else
  localparam state_t FINAL = DONE;
`endif

  state_t            state, state_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W-2:0] cnt;
  logic [1:0]        idx;
  logic [31:0]       asm_word;
  logic              xfer;
  logic [15:0]       len_in;
  logic              last_word;

  assign xfer      = in_valid && in_ready;
  assign len_in    = {in_data, len_lo};
  assign last_word = (16'(cnt) + 16'd1) == len;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over LEN_LO, LEN_HI and every data byte of the current frame.
  always_ff @(posedge clk) begin
    if (resetn || state == IDLE) begin
      csum <= '0;
    end else if (xfer && (state == LEN0 || state == LEN1 || state == DATA)) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (xfer && in_data == 8'hA5) state_nxt = LEN0;
      LEN0:  if (xfer) state_nxt = LEN1;
      LEN1: begin
        if (xfer) begin
          if ({1'b0, len_in} > MAX_WORDS) begin
            state_nxt = ERR;
          end else if (len_in == 16'd0) begin
            state_nxt = FINAL;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA:  if (xfer && idx == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = last_word ? FINAL : DATA;
`ifdef BOOT_CHECKSUM_EN
      CSUM:  if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
`endif
      default: state_nxt = state;
    endcase
  end

  // WRITE never overlaps an accepted byte because in_ready is low there.
  always_ff @(posedge clk) begin
    if (resetn) begin
      len_lo   <= '0;
      len      <= '0;
      cnt      <= '0;
      idx      <= '0;
      asm_word <= '0;
    end else if (xfer) begin
      case (state)
        LEN0: len_lo <= in_data;
        LEN1: begin
          len <= len_in;
          cnt <= '0;
          idx <= '0;
        end
        DATA: begin
          asm_word[8*idx +: 8] <= in_data;
          idx                  <= idx + 2'd1;
        end
        default: ;
      endcase
    end else if (state == WRITE) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    core_resetn = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    word_cnt    = '0;
    if (!resetn) begin
      word_cnt = cnt;
      case (state)
        IDLE, LEN0, LEN1, DATA, CSUM: in_ready = 1'b1;
        WRITE: begin
          mem_we    = 1'b1;
          mem_addr  = {cnt[ADDR_W-3:0], 2'b00};
          mem_wdata = asm_word;
        end
        DONE: begin
          core_resetn = 1'b0;
          done        = 1'b1;
        end
        ERR: error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized self-checking bench for boot_loader against a frame-level model
module tb_boot_loader;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, core_resetn, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-2:0] word_cnt;

  int total = 0;
  int bad = 0;
  int ready_bad = 0;
  int lat_bad = 0;
  bit prev_xfer = 1'b0;

  logic [7:0]  tx[$];
  logic [31:0] exp_w[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_resetn(core_resetn), .done(done), .error(error), .word_cnt(word_cnt)
  );

  // Observes every RAM write plus the ready/strobe timing relations.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      if (!prev_xfer) lat_bad++;
    end
    if (!resetn && ((mem_we && in_ready) || (!mem_we && !in_ready && !done && !error)))
      ready_bad++;
    prev_xfer = in_valid && in_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_resetn", core_resetn, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_cnt", word_cnt, 0);
    @(posedge clk); #1;
    resetn = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Appends optional junk, header, LSB-first words of exp_w and (if enabled) the checksum.
  task automatic build_frame(input int junk);
    logic [7:0]  b;
    logic [15:0] n;
    logic [31:0] w;
    int          hdr;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom_range(255));
      if (b == 8'hA5) b = 8'h00;
      tx.push_back(b);
    end
    n = 16'(exp_w.size());
    hdr = tx.size();
    tx.push_back(8'hA5);
    tx.push_back(n[7:0]);
    tx.push_back(n[15:8]);
    foreach (exp_w[i]) begin
      w = exp_w[i];
      for (int k = 0; k < 4; k++) tx.push_back(w[8*k +: 8]);
    end
`ifdef BOOT_CHECKSUM_EN
    b = 8'h00;
    for (int j = hdr + 1; j < tx.size(); j++) b = b ^ tx[j];
    tx.push_back(b);
`else
    hdr = hdr + 0;
`endif
  endtask

  task automatic send(input bit gaps, input int budget);
    int i = 0;
    int cyc = 0;
    bit acc;
    @(posedge clk); #1;
    while (i < tx.size() && cyc < budget) begin
      in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_data = in_valid ? tx[i] : 8'($urandom_range(255));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("send_all_bytes", i, tx.size());
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    @(negedge clk);
    while (!(done || error) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done || error, 1);
  endtask

  task automatic verify(input string tag);
    int nb = 0;
    chk({tag, "_wr_count"}, wr_addr_q.size(), exp_w.size());
    foreach (exp_w[i]) begin
      if (i >= wr_addr_q.size()) nb++;
      else if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== exp_w[i]) nb++;
    end
    chk({tag, "_wr_content"}, nb, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_core_resetn"}, core_resetn, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_word_cnt"}, word_cnt, exp_w.size());
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);

    // Directed frame with leading junk, random valid gaps
    tx.delete();
    exp_w = '{32'h0000_0013, 32'h0000_006F};
    tx.push_back(8'h00);
    tx.push_back(8'h13);
    build_frame(0);
    send(1'b1, 300);
    wait_end("t1_end");
    verify("t1");

    // Same frame with in_valid held high throughout
    do_reset();
    tx.delete();
    tx.push_back(8'h00);
    tx.push_back(8'h13);
    build_frame(0);
    send(1'b0, 300);
    wait_end("t2_end");
    verify("t2");

    // Random frames
    for (int r = 0; r < 6; r++) begin
      do_reset();
      tx.delete();
      exp_w.delete();
      repeat ($urandom_range(1, 9)) exp_w.push_back($urandom());
      build_frame($urandom_range(0, 3));
      send(r[0], 600);
      wait_end("rand_end");
      verify("rand");
    end

    // Oversized length is rejected immediately after LEN_HI
    do_reset();
    tx = '{8'hA5, 8'h01, 8'h10};
    send(1'b0, 50);
    @(negedge clk);
    chk("len4097_error", error, 1);
    chk("len4097_done", done, 0);
    chk("len4097_core_resetn", core_resetn, 1);
    chk("len4097_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("len4097_no_write", wr_addr_q.size(), 0);

    // Full-capacity frame
    do_reset();
    tx.delete();
    exp_w.delete();
    repeat (4096) exp_w.push_back($urandom());
    build_frame(0);
    send(1'b0, 30000);
    wait_end("full_end");
    verify("full");

    // Reset after 2 of 4 bytes of word 1, then a clean frame
    do_reset();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(1'b1, 200);
    repeat (3) @(negedge clk);
    chk("partial_writes", wr_addr_q.size(), 1);
    chk("partial_word_cnt", word_cnt, 1);
    do_reset();
    tx.delete();
    exp_w = '{$urandom(), $urandom(), $urandom()};
    build_frame(1);
    send(1'b1, 300);
    wait_end("reload_end");
    verify("reload");

    // Reset sampled in the WRITE cycle suppresses the strobe
    do_reset();
    tx = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(1'b0, 50);
    resetn = 1'b1;
    @(negedge clk);
    chk("write_reset_we", mem_we, 0);
    chk("write_reset_no_write", wr_addr_q.size(), 0);

    // Empty frame
    do_reset();
    tx.delete();
    exp_w.delete();
    build_frame(2);
    send(1'b0, 50);
    wait_end("n0_end");
    verify("n0");

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum: word lands in RAM, then the frame is rejected
    do_reset();
    tx.delete();
    exp_w = '{$urandom()};
    build_frame(0);
    tx[tx.size()-1] = tx[tx.size()-1] ^ 8'hFF;
    send(1'b0, 50);
    wait_end("badcs_end");
    chk("badcs_wr_count", wr_addr_q.size(), 1);
    chk("badcs_error", error, 1);
    chk("badcs_done", done, 0);
    chk("badcs_core_resetn", core_resetn, 1);
`endif

    chk("ready_only_low_in_write", ready_bad, 0);
    chk("we_one_cycle_after_4th_byte", lat_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader sitting directly upstream of the core's 16 KB unified RAM and the core's reset input. It receives a framed image over a valid/ready byte interface, assembles little-endian 32-bit words, writes them into RAM from word 0 (core address 0x80000000) upward, then releases the core from reset. Until a frame is accepted, the core is held in reset.

## Interface
- ADDR_W, 14: RAM byte-address width; capacity is 2^(ADDR_W-2) words (4096).
- clk  in  1  sole clock; all logic on posedge.
- resetn  in  1  synchronous, active-high reset (asserted = 1).
- in_valid  in  1  source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid && in_ready.
- mem_we  out  1  one-cycle full-word RAM write strobe.
- mem_addr  out  ADDR_W  byte address of the write, always word aligned (bits [1:0] = 0).
- mem_wdata  out  32  word to write.
- core_resetn  out  1  reset to the core, same polarity as resetn (1 = core held in reset).
- done  out  1  image loaded, core released.
- error  out  1  frame rejected; core stays in reset.
- word_cnt  out  ADDR_W-1  words written so far in the current frame.

## Operation
- Frame: magic 0xA5, LEN_LO, LEN_HI (16-bit word count N), then N words (4 bytes each, LSB first), then checksum byte (only with the macro; see Configuration).
- States: IDLE -> LEN0 -> LEN1 -> DATA <-> WRITE -> (CSUM) -> DONE; any state -> ERR on a fault.
- IDLE: accept bytes; 0xA5 -> LEN0; any other byte is discarded, stay in IDLE.
- LEN0: latch LEN_LO -> LEN1. LEN1: latch LEN_HI. N > 2^(ADDR_W-2) -> ERR. N = 0 -> CSUM (macro on) or DONE. Otherwise -> DATA with byte index 0 and word_cnt 0.
- DATA: shift bytes into the assembly register at lane = byte index. On the 4th byte -> WRITE.
- WRITE: one cycle. mem_we = 1, mem_addr = word_cnt << 2, mem_wdata = assembled word. Then increment word_cnt. If word_cnt + 1 == N -> CSUM/DONE; else -> DATA.
- DONE: core_resetn = 0, done = 1, in_ready = 0. Held until resetn.
- ERR: core_resetn = 1, error = 1, in_ready = 0. Held until resetn.
- RAM is never cleared by the loader. Words beyond N keep their prior contents.

## Timing
- Values during and after reset: state IDLE, in_ready 0 while resetn = 1 and 1 from the cycle after release, mem_we 0, mem_addr 0, mem_wdata 0, core_resetn 1, done 0, error 0, word_cnt 0.
- in_ready = 1 exactly in IDLE, LEN0, LEN1, DATA, CSUM. It is 0 in WRITE, DONE, ERR and during reset.
- At most one byte is accepted per cycle. in_valid may stay high across WRITE; that byte is accepted in the following DATA cycle.
- Minimum cost per word is 5 cycles (4 accept + 1 WRITE).
- mem_we asserts exactly one cycle after the cycle that accepts the word's 4th byte.
- core_resetn falls in the cycle after the final accepting transfer (N = 0, macro off) or after the final WRITE/CSUM cycle.
- resetn asserted in any state, including WRITE: the next state is IDLE with all outputs at reset values. A partially assembled word is dropped. mem_we is 0 in the cycle reset is sampled.
- word_cnt saturation: impossible by the length check. N = 4096 writes addresses 0..0x3FFC; the counter is ADDR_W-1 bits wide and holds 4096.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - After the last WRITE (or after LEN1 when N = 0), state CSUM accepts one byte.
  - That byte must equal the XOR of LEN_LO, LEN_HI and all data bytes.
  - Match -> DONE; mismatch -> ERR.
  - Words already written remain in RAM.
- BOOT_CHECKSUM_EN undefined:
  - No CSUM state and no checksum byte.
  - Transition goes straight to DONE.

## Test plan
- Bytes 0x00,0x13,0xA5,0x02,0x00, then 0x13,0x00,0x00,0x00, 0x6F,0x00,0x00,0x00 (+ checksum 0x7E if enabled) -> leading junk ignored; mem writes {0x0000: 0x00000013, 0x0004: 0x0000006F}; done = 1, core_resetn = 0.
- Same frame with in_valid held high continuously -> in_ready drops exactly in each WRITE cycle; no byte lost or duplicated; 2 mem_we pulses.
- LEN = 0x1001 (4097) -> error = 1 right after LEN_HI; no mem_we; core_resetn stays 1.
- resetn pulsed after 2 of 4 bytes of word 1 -> no write for that word; after release, a new full frame loads correctly from address 0.
- BOOT_CHECKSUM_EN: a 1-word frame with a wrong checksum byte -> word written, then error = 1, core_resetn = 1.
- N = 0 frame -> no mem_we; done = 1.
